// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexes four BCD digits onto a common-anode 4-digit 7-segment display with colon and blink-on-done.
// Latency: an/seg/dp are registered; they reflect digit_idx and the live inputs one clock after the sampling edge.
// Backpressure: none; the scan free-runs every cycle and the digit inputs are sampled without handshake.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   enable                low blanks all digits, scan keeps running
//   done                  timer expired, makes the display blink
//   m_tens/m_ones         minutes digits (BCD)
//   s_tens/s_ones         seconds digits (BCD)
//   an[3:0]               active-low digit enables, an[0] = s_ones, an[3] = m_tens
//   seg[6:0]              active-low segments {g,f,e,d,c,b,a}
//   dp                    active-low decimal point, used as the colon
//
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks the m_tens digit when it is zero.

module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       done,
    input  logic [2:0] m_tens,
    input  logic [3:0] m_ones,
    input  logic [2:0] s_tens,
    input  logic [3:0] s_ones,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int TW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(BLINK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic [1:0]    digit_idx;
    logic [SW-1:0] scan_cnt;
    logic          blink_phase;

    logic          slot_tick;
    logic          scan_tick;
    logic          visible;
    logic          lz_blank;
    logic [3:0]    digit_val;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;   // out-of-range value shows a dash
        endcase
        return s;
    endfunction

    assign slot_tick = (tick_cnt == TICK_LAST);
    assign scan_tick = slot_tick && (digit_idx == 2'd3);

    // Scan position counters: never gated by enable so re-enabling resumes in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            digit_idx <= 2'd0;
        end else begin
            tick_cnt  <= slot_tick ? '0 : tick_cnt + 1'b1;
            if (slot_tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
        end
    end

    // Blink generator: held in the visible phase while done is low, so every
    // rising done starts with a full visible half-period.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            blink_phase <= 1'b1;
        end else if (!done) begin
            scan_cnt    <= '0;
            blink_phase <= 1'b1;
        end else if (scan_tick) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt    <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                scan_cnt    <= scan_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        digit_val = 4'd0;
        case (digit_idx)
            2'd0:    digit_val = s_ones;
            2'd1:    digit_val = {1'b0, s_tens};
            2'd2:    digit_val = m_ones;
            default: digit_val = {1'b0, m_tens};
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign lz_blank = (digit_idx == 2'd3) && (m_tens == 3'd0);
`else
    assign lz_blank = 1'b0;
`endif

    assign visible = enable && (!done || blink_phase);

    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (visible && !lz_blank) begin
            an_nxt  = ~(4'b0001 << digit_idx);
            seg_nxt = decode(digit_val);
        end
        // Colon sits between minutes and seconds, lit with the m_ones digit.
        if (visible && (digit_idx == 2'd2)) begin
            dp_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int R = 4;
    localparam int B = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       done;
    logic [2:0] m_tens;
    logic [3:0] m_ones;
    logic [2:0] s_tens;
    logic [3:0] s_ones;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int   checks;
    int   failures;
    int   n;          // edges since reset release
    int   d;          // edge at which done last rose (scan-aligned)
    logic done_prev;
    exp_t q[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .done   (done),
        .m_tens (m_tens),
        .m_ones (m_ones),
        .s_tens (s_tens),
        .s_ones (s_ones),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and push what the outputs must show after it.
    task automatic step();
        exp_t       e;
        int         idx;
        logic       vis;
        logic [3:0] v;
        @(posedge clk);
        #1;
        if (reset) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
            n = 0;
            d = 0;
            done_prev = done;
        end else begin
            if (done && !done_prev) d = n;
            done_prev = done;
            idx = (n / R) % 4;
            vis = enable && (!done || (((n - d) / (4 * R * B)) % 2 == 0));
            case (idx)
                0:       v = s_ones;
                1:       v = {1'b0, s_tens};
                2:       v = m_ones;
                default: v = {1'b0, m_tens};
            endcase
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
            if (vis) begin
                e.an  = ~(4'b0001 << idx);
                e.seg = (v <= 4'd9) ? seg_tab[v] : 7'h3F;
                e.dp  = (idx == 2) ? 1'b0 : 1'b1;
            end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (idx == 3 && m_tens == 3'd0) begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end
`endif
            n++;
        end
        q.push_back(e);
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic align_scan();
        for (int i = 0; i < 16 && (n % (4 * R)) != 0; i++) step();
    endtask

    // Monitor: the display presents a new word every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                failures++;
                $display("FAIL disp t=%0t an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                         $time, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    initial begin
        checks = 0; failures = 0; n = 0; d = 0; done_prev = 1'b0;
        reset = 1'b1; enable = 1'b1; done = 1'b0;
        m_tens = 3'd1; m_ones = 4'd2; s_tens = 3'd3; s_ones = 4'd4;

        // Reset and scan order
        steps(3);
        reset = 1'b0;
        steps(32);

        // Decode sweep on s_ones, including an out-of-range value
        for (int v = 0; v <= 10; v++) begin
            s_ones = 4'(v);
            steps(16);
        end
        s_ones = 4'd4;
        m_ones = 4'd9; s_tens = 3'd5;
        steps(16);

        // Enable dropped mid slot 2, then restored
        align_scan();
        steps(10);
        enable = 1'b0;
        steps(5);
        enable = 1'b1;
        steps(10);

        // Blink: two visible scans, two blank scans; drop done while blank
        align_scan();
        done = 1'b1;
        steps(80);
        done = 1'b0;
        align_scan();
        done = 1'b1;
        steps(40);
        done = 1'b0;
        steps(8);

        // Reset during slot 3 with done high
        align_scan();
        done = 1'b1;
        steps(13);
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(40);
        done = 1'b0;
        steps(4);

        // Leading zero on minutes tens
        align_scan();
        m_tens = 3'd0;
        steps(20);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the egg timer.
- Consumes the timer's BCD digit outputs (m_tens, m_ones, s_tens, s_ones) and the timer-expired flag.
- Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display, with a colon point and blink-on-done.
- Instantiated beside Egg_Timer in the top level, on the same clock.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is lit per scan slot; legal range 2 or more.
- BLINK_DIV, 50, full scans per blink half-period while done is high; legal range 1 or more.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  display enable; low blanks all digits without stopping the scan.
- done  input  1  timer expired; high makes the display blink.
- m_tens  input  3  minutes tens digit, BCD 0-5.
- m_ones  input  4  minutes ones digit, BCD 0-9.
- s_tens  input  3  seconds tens digit, BCD 0-5.
- s_ones  input  4  seconds ones digit, BCD 0-9.
- an  output  4  digit enables, active-low; an[0] is the rightmost digit (s_ones), an[3] is m_tens.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; used as the colon.

Behaviour:
- Everything is clocked on the rising edge of clk. Reset is synchronous, active-high, one clock, no asynchronous paths.
- Reset values:
  - an = 4'b1111, seg = 7'h7F, dp = 1.
  - tick_cnt = 0, digit_idx = 0, scan_cnt = 0, blink_phase = 1 (visible).
- Reset asserted mid-scan returns all of the above to their reset values on that edge.
- tick_cnt counts 0 to REFRESH_DIV-1, then wraps to 0. The wrap cycle is the slot tick.
- digit_idx advances on each slot tick: 0 → 1 → 2 → 3 → 0. Index 0 is s_ones, 1 is s_tens, 2 is m_ones, 3 is m_tens.
- Outputs are registered with 1-cycle latency. On every edge, an, seg and dp are computed from the current digit_idx and the live digit inputs. A digit_idx change therefore appears on an/seg one cycle later.
- an: exactly one bit low (bit digit_idx) when the display is visible, otherwise 4'b1111.
- Visible means enable = 1 AND (done = 0 OR blink_phase = 1).
- Not visible: seg = 7'h7F and dp = 1.
- Decoder, active-low hex, values 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
- Any value above 9 decodes to a dash, 7'h3F (segment g only). 3-bit tens inputs are zero-extended before decoding.
- dp = 0 only when digit_idx = 2 and the display is visible (the colon between minutes and seconds). Otherwise dp = 1.
- Blink:
  - scan_cnt increments on each slot tick where digit_idx wraps 3 → 0.
  - When scan_cnt reaches BLINK_DIV-1 on such a tick, it clears to 0 and blink_phase toggles.
  - While done = 0, scan_cnt = 0 and blink_phase = 1 every cycle. A rising done therefore always begins with a visible half-period.
- enable = 0 does not stop tick_cnt, digit_idx or the blink logic. Re-enabling resumes at the current scan position.
- Digit inputs may change at any time. Each output cycle reflects the value present at that edge; no internal latching of digits.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: when digit_idx = 3 and m_tens = 0, an stays 4'b1111 and seg = 7'h7F during that slot, regardless of visibility. All other digits are unaffected.
- Undefined: m_tens = 0 displays "0" like any other digit.

Test Plan:
- Reset and scan order (REFRESH_DIV=4, BLINK_DIV=2, enable=1, done=0, digits 1,2,3,4 as m_tens..s_ones):
  - hold reset for 3 cycles → an=1111, seg=7F, dp=1.
  - after release → an follows 1110, 1101, 1011, 0111, each held 4 cycles.
  - seg shows 19, 30, 24, 79 in matching slots.
- Colon and decode: sweep s_ones 0-9, then force 4'hA → seg matches the table, then 3F for A. dp=0 only while an=1011.
- Enable: drop enable mid-slot 2 → next edge an=1111, seg=7F, dp=1. Raise enable → output resumes at the slot digit_idx currently points to, with no restart at 0.
- Blink (REFRESH_DIV=4, BLINK_DIV=2):
  - raise done → display visible for 2 scans (32 cycles), blank for 32 cycles, repeating.
  - drop done while blank → visible on the next edge.
- Reset mid-operation: assert reset in slot 3 with done high → all state and outputs are at reset values on that edge. After release the scan restarts at an=1110.
- SEG7_LEADING_ZERO_BLANK_EN with m_tens=0:
  - defined → an never equals 0111.
  - undefined → an=0111 with seg=40.
